// File: rtl/dp_sram_clr.sv
// Dual-port SRAM with byte-masked writes and a hardware clear sweep.
// After reset or a flush request the array is zeroed one word per clock;
// port accesses are accepted only once the sweep has finished.
module dp_sram_clr #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned RDW_MODE   = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    output logic                      ready,
    input  logic                      csb0,
    input  logic                      web0,
    input  logic [DATA_WIDTH/8-1:0]   wmask0,
    input  logic [ADDR_WIDTH-1:0]     addr0,
    input  logic [DATA_WIDTH-1:0]     din0,
    output logic [DATA_WIDTH-1:0]     dout0,
    input  logic                      csb1,
    input  logic                      web1,
    input  logic [DATA_WIDTH/8-1:0]   wmask1,
    input  logic [ADDR_WIDTH-1:0]     addr1,
    input  logic [DATA_WIDTH-1:0]     din1,
    output logic [DATA_WIDTH-1:0]     dout1
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned NB    = DATA_WIDTH / 8;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   cnt;
    logic [ADDR_WIDTH-1:0]   cnt_nxt;
    logic                    acc_en;
    logic                    wr0;
    logic                    wr1;
    logic                    rd0;
    logic                    rd1;
    logic [DATA_WIDTH-1:0]   post0;
    logic [DATA_WIDTH-1:0]   post1;
    logic [DATA_WIDTH-1:0]   rdat0;
    logic [DATA_WIDTH-1:0]   rdat1;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // State and sweep counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: sweep until the last word is cleared, flush restarts it.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ready     = 1'b0;
        acc_en    = 1'b0;
        unique case (state)
            ST_CLEAR: begin
                if (flush) begin
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == '1) begin
                        state_nxt = ST_READY;
                    end
                end
            end
            ST_READY: begin
                ready = 1'b1;
                if (flush) begin
                    state_nxt = ST_CLEAR;
                    cnt_nxt   = '0;
                end else begin
                    acc_en = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_CLEAR;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Decode port requests; they only count while accesses are enabled.
    always_comb begin
        wr0 = acc_en && !csb0 && !web0;
        wr1 = acc_en && !csb1 && !web1;
        rd0 = acc_en && !csb0 &&  web0;
        rd1 = acc_en && !csb1 &&  web1;
    end

    // Post-write word at each port's address: port 0 bytes first, then port 1
    // bytes on top, so port 1 wins overlapping bytes and both ports commit
    // the identical merged word when they target the same address.
    always_comb begin
        post0 = mem[addr0];
        post1 = mem[addr1];
        for (int unsigned i = 0; i < NB; i++) begin
            if (wr0 && wmask0[i]) begin
                post0[i*8 +: 8] = din0[i*8 +: 8];
                if (addr1 == addr0) begin
                    post1[i*8 +: 8] = din0[i*8 +: 8];
                end
            end
        end
        for (int unsigned i = 0; i < NB; i++) begin
            if (wr1 && wmask1[i]) begin
                post1[i*8 +: 8] = din1[i*8 +: 8];
                if (addr0 == addr1) begin
                    post0[i*8 +: 8] = din1[i*8 +: 8];
                end
            end
        end
    end

    // Read data source: stored word, or the merged post-write word in new-data mode.
    always_comb begin
        rdat0 = mem[addr0];
        rdat1 = mem[addr1];
        if (RDW_MODE == 1) begin
            rdat0 = post0;
            rdat1 = post1;
        end
    end

    // Array write: sweep zeroes one word per edge, otherwise merged port writes.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[cnt] <= '0;
        end else begin
            if (wr0) begin
                mem[addr0] <= post0;
            end
            if (wr1) begin
                mem[addr1] <= post1;
            end
        end
    end

    // Registered read outputs; hold unless a read is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout0 <= '0;
            dout1 <= '0;
        end else begin
            if (rd0) begin
                dout0 <= rdat0;
            end
            if (rd1) begin
                dout1 <= rdat1;
            end
        end
    end

endmodule

// File: tb/tb_dp_sram_clr.sv
// Self-checking bench for dp_sram_clr: one instance per read-during-write
// mode sharing all inputs, checked against a word-level reference model.
module tb_dp_sram_clr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        csb0, web0, csb1, web1;
    logic [3:0]  wmask0, wmask1;
    logic [7:0]  addr0, addr1;
    logic [31:0] din0, din1;
    logic        ready_a, ready_b;
    logic [31:0] dout0_a, dout1_a, dout0_b, dout1_b;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] ref_mem [256];
    logic [31:0] ref_d0a, ref_d1a, ref_d0b, ref_d1b;
    int          clear_left;

    dp_sram_clr #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RDW_MODE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .ready(ready_a),
        .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0), .dout0(dout0_a),
        .csb1(csb1), .web1(web1), .wmask1(wmask1), .addr1(addr1), .din1(din1), .dout1(dout1_a)
    );

    dp_sram_clr #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RDW_MODE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .ready(ready_b),
        .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0), .dout0(dout0_b),
        .csb1(csb1), .web1(web1), .wmask1(wmask1), .addr1(addr1), .din1(din1), .dout1(dout1_b)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not complete, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic model_reset();
        clear_left = 256;
        ref_d0a = '0; ref_d1a = '0; ref_d0b = '0; ref_d1b = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    endtask

    // Word as it stands once this cycle's writes land; port 1 bytes win.
    function automatic logic [31:0] post_word(input logic [7:0] a);
        logic [31:0] w;
        w = ref_mem[a];
        for (int i = 0; i < 4; i++) begin
            if (!csb0 && !web0 && addr0 == a && wmask0[i]) w[8*i +: 8] = din0[8*i +: 8];
            if (!csb1 && !web1 && addr1 == a && wmask1[i]) w[8*i +: 8] = din1[8*i +: 8];
        end
        return w;
    endfunction

    // Advance the model by one clock using the present inputs, then the clock.
    task automatic tick();
        logic [31:0] p0, p1;
        if (!rst_n) begin
            model_reset();
        end else if (clear_left > 0) begin
            clear_left = flush ? 256 : clear_left - 1;
        end else if (flush) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = '0;
            clear_left = 256;
        end else begin
            p0 = post_word(addr0);
            p1 = post_word(addr1);
            if (!csb0 && web0) begin ref_d0a = ref_mem[addr0]; ref_d0b = p0; end
            if (!csb1 && web1) begin ref_d1a = ref_mem[addr1]; ref_d1b = p1; end
            if (!csb0 && !web0) ref_mem[addr0] = p0;
            if (!csb1 && !web1) ref_mem[addr1] = p1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 1'b0;
        csb0 = 1'b1; web0 = 1'b1; wmask0 = '0; addr0 = '0; din0 = '0;
        csb1 = 1'b1; web1 = 1'b1; wmask1 = '0; addr1 = '0; din1 = '0;
    endtask

    task automatic wr_port(input int p, input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
        if (p == 0) begin csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m; end
        else        begin csb1 = 1'b0; web1 = 1'b0; addr1 = a; din1 = d; wmask1 = m; end
    endtask

    task automatic rd_port(input int p, input logic [7:0] a);
        if (p == 0) begin csb0 = 1'b0; web0 = 1'b1; addr0 = a; end
        else        begin csb1 = 1'b0; web1 = 1'b1; addr1 = a; end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        model_reset();
        @(posedge clk);
        #1;
        checks++;
        if (ready_a !== 1'b0 || ready_b !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: got %b/%b expected 0", ready_a, ready_b);
        end
        checks++;
        if ({dout0_a, dout1_a, dout0_b, dout1_b} !== 128'h0) begin
            failures++;
            $display("FAIL reset_dout: got %h %h %h %h expected 0", dout0_a, dout1_a, dout0_b, dout1_b);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_sweep();
        logic [7:0] a;
        for (int i = 0; i < 256; i++) begin
            tick();
            checks++;
            if (ready_a !== (i == 255) || ready_b !== (i == 255)) begin
                failures++;
                $display("FAIL sweep_ready edge %0d: got %b/%b expected %b", i + 1, ready_a, ready_b, i == 255);
            end
        end
        for (int i = 0; i < 16; i++) begin
            a = 8'($urandom);
            rd_port(0, a);
            rd_port(1, ~a);
            tick();
            checks++;
            if (dout0_a !== 32'h0 || dout1_a !== 32'h0 || dout0_b !== 32'h0 || dout1_b !== 32'h0) begin
                failures++;
                $display("FAIL sweep_zero addr %h: got %h %h %h %h expected 0", a, dout0_a, dout1_a, dout0_b, dout1_b);
            end
        end
        idle();
    endtask

    task automatic test_byte_mask();
        idle();
        wr_port(0, 8'h10, 32'hDEADBEEF, 4'b0101);
        tick();
        idle();
        rd_port(0, 8'h10);
        tick();
        idle();
        checks++;
        if (dout0_a !== 32'h00AD00EF || dout0_b !== 32'h00AD00EF) begin
            failures++;
            $display("FAIL byte_mask: got %h/%h expected 00ad00ef", dout0_a, dout0_b);
        end
    endtask

    task automatic test_dual_write();
        idle();
        wr_port(0, 8'h05, 32'h11111111, 4'hF);
        wr_port(1, 8'h05, 32'h22222222, 4'hF);
        tick();
        idle();
        rd_port(0, 8'h05);
        rd_port(1, 8'h05);
        tick();
        checks++;
        if (dout0_a !== 32'h22222222 || dout1_a !== 32'h22222222 || dout0_b !== 32'h22222222) begin
            failures++;
            $display("FAIL dual_write_full: got %h %h %h expected 22222222", dout0_a, dout1_a, dout0_b);
        end
        idle();
        wr_port(0, 8'h06, 32'h11111111, 4'hF);
        wr_port(1, 8'h06, 32'h22222222, 4'b0011);
        tick();
        idle();
        rd_port(1, 8'h06);
        tick();
        idle();
        checks++;
        if (dout1_a !== 32'h11112222 || dout1_b !== 32'h11112222) begin
            failures++;
            $display("FAIL dual_write_bytes: got %h/%h expected 11112222", dout1_a, dout1_b);
        end
    endtask

    task automatic test_rdw();
        idle();
        wr_port(0, 8'h07, 32'hAAAAAAAA, 4'hF);
        tick();
        idle();
        wr_port(0, 8'h07, 32'h55555555, 4'hF);
        rd_port(1, 8'h07);
        tick();
        checks++;
        if (dout1_a !== 32'hAAAAAAAA) begin
            failures++;
            $display("FAIL rdw_old: got %h expected aaaaaaaa", dout1_a);
        end
        checks++;
        if (dout1_b !== 32'h55555555) begin
            failures++;
            $display("FAIL rdw_new: got %h expected 55555555", dout1_b);
        end
        idle();
        wr_port(1, 8'h07, 32'h0F0F0F0F, 4'b0011);
        rd_port(0, 8'h07);
        tick();
        checks++;
        if (dout0_a !== 32'h55555555 || dout0_b !== 32'h55550F0F) begin
            failures++;
            $display("FAIL rdw_partial: got %h/%h expected 55555555/55550f0f", dout0_a, dout0_b);
        end
        idle();
        rd_port(0, 8'h07);
        rd_port(1, 8'h07);
        tick();
        idle();
        checks++;
        if (dout0_a !== 32'h55550F0F || dout1_a !== 32'h55550F0F || dout1_b !== 32'h55550F0F) begin
            failures++;
            $display("FAIL dual_read: got %h %h %h expected 55550f0f", dout0_a, dout1_a, dout1_b);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            flush  = ($urandom_range(0, 149) == 0);
            csb0   = ($urandom_range(0, 3) == 0);
            web0   = 1'($urandom);
            wmask0 = 4'($urandom);
            addr0  = 8'($urandom_range(0, 7));
            din0   = $urandom;
            csb1   = ($urandom_range(0, 3) == 0);
            web1   = 1'($urandom);
            wmask1 = 4'($urandom);
            addr1  = 8'($urandom_range(0, 7));
            din1   = $urandom;
            tick();
            checks++;
            if (ready_a !== (clear_left == 0) || ready_b !== (clear_left == 0)) begin
                failures++;
                $display("FAIL rand_ready cyc %0d: got %b/%b expected %b", n, ready_a, ready_b, clear_left == 0);
            end
            checks++;
            if (dout0_a !== ref_d0a || dout1_a !== ref_d1a) begin
                failures++;
                $display("FAIL rand_dout_old cyc %0d: got %h %h expected %h %h", n, dout0_a, dout1_a, ref_d0a, ref_d1a);
            end
            checks++;
            if (dout0_b !== ref_d0b || dout1_b !== ref_d1b) begin
                failures++;
                $display("FAIL rand_dout_new cyc %0d: got %h %h expected %h %h", n, dout0_b, dout1_b, ref_d0b, ref_d1b);
            end
        end
        idle();
        while (clear_left > 0) tick();
        for (int a = 0; a < 8; a++) begin
            rd_port(0, 8'(a));
            tick();
            checks++;
            if (dout0_a !== ref_mem[a]) begin
                failures++;
                $display("FAIL rand_final addr %0d: got %h expected %h", a, dout0_a, ref_mem[a]);
            end
        end
        idle();
    endtask

    task automatic test_flush();
        idle();
        wr_port(0, 8'h03, 32'hCAFEF00D, 4'hF);
        wr_port(1, 8'h04, 32'h87654321, 4'hF);
        tick();
        idle();
        flush = 1'b1;
        wr_port(0, 8'h09, 32'h99999999, 4'hF);
        tick();
        checks++;
        if (ready_a !== 1'b0) begin
            failures++;
            $display("FAIL flush_drop_ready: got %b expected 0", ready_a);
        end
        idle();
        wr_port(0, 8'h03, 32'hFFFFFFFF, 4'hF);
        for (int i = 0; i < 100; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 256; i++) begin
            tick();
            checks++;
            if (ready_a !== (i == 255)) begin
                failures++;
                $display("FAIL flush_restart_ready edge %0d: got %b expected %b", i + 1, ready_a, i == 255);
            end
        end
        idle();
        rd_port(0, 8'h03);
        rd_port(1, 8'h04);
        tick();
        checks++;
        if (dout0_a !== 32'h0 || dout1_a !== 32'h0) begin
            failures++;
            $display("FAIL flush_cleared: got %h %h expected 0", dout0_a, dout1_a);
        end
        idle();
        rd_port(0, 8'h09);
        tick();
        idle();
        checks++;
        if (dout0_a !== 32'h0) begin
            failures++;
            $display("FAIL flush_write_lost: got %h expected 0", dout0_a);
        end
    endtask

    task automatic test_async_reset();
        idle();
        wr_port(0, 8'h20, 32'h12345678, 4'hF);
        tick();
        idle();
        rd_port(0, 8'h20);
        tick();
        checks++;
        if (dout0_a !== 32'h12345678) begin
            failures++;
            $display("FAIL areset_pre: got %h expected 12345678", dout0_a);
        end
        idle();
        wr_port(1, 8'h20, 32'hFFFFFFFF, 4'hF);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dout0_a !== 32'h0 || ready_a !== 1'b0 || dout0_b !== 32'h0 || ready_b !== 1'b0) begin
            failures++;
            $display("FAIL areset_immediate: got dout %h/%h ready %b/%b expected 0", dout0_a, dout0_b, ready_a, ready_b);
        end
        idle();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) begin
            tick();
            checks++;
            if (ready_a !== (i == 255)) begin
                failures++;
                $display("FAIL areset_sweep edge %0d: got %b expected %b", i + 1, ready_a, i == 255);
            end
        end
        rd_port(0, 8'h20);
        tick();
        idle();
        checks++;
        if (dout0_a !== 32'h0) begin
            failures++;
            $display("FAIL areset_cleared: got %h expected 0", dout0_a);
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_byte_mask();
        test_dual_write();
        test_rdw();
        test_random();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dp_sram_clr.md
DP_SRAM_CLR -- requirements
Module: dp_sram_clr

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: word width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8: address width; DEPTH = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter RDW_MODE, default 0: cross-port read-during-write result; 0 = old data, 1 = new data.
REQ-004 SHALL have the clock and reset ports clk and rst_n; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port flush  input  1  request a full-array clear, sampled at clk edge.
REQ-008 SHALL have port ready  output  1  array cleared and accepting accesses.
REQ-009 SHALL have, for p in {0,1}, port csbp  input  1  active-low chip select.
REQ-010 SHALL have, for p in {0,1}, port webp  input  1  active-low write enable (0 = write, 1 = read).
REQ-011 SHALL have, for p in {0,1}, port wmaskp  input  DATA_WIDTH/8  byte write enables, bit i covers din[8i+7:8i].
REQ-012 SHALL have, for p in {0,1}, port addrp  input  ADDR_WIDTH  word address.
REQ-013 SHALL have, for p in {0,1}, port dinp  input  DATA_WIDTH  write data.
REQ-014 SHALL have, for p in {0,1}, port doutp  output  DATA_WIDTH  registered read data.

Function
REQ-015 SHALL implement a two-state FSM, CLEAR and READY; ready = 1 exactly in READY.
REQ-016 CLEAR SHALL write all-zero to the word at an ADDR_WIDTH-bit counter on each clk edge, then increment the counter.
REQ-017 SHALL go CLEAR->READY on the edge that clears address DEPTH-1; ready is therefore first high after DEPTH edges.
REQ-018 flush=1 in READY SHALL go to CLEAR with the counter at 0 on that edge; the port accesses presented on that edge are dropped.
REQ-019 flush=1 in CLEAR SHALL restart the counter at 0 (clear restarts; no early exit).
REQ-020 While ready=0, port requests SHALL be ignored: no array write, and doutp holds its value.
REQ-021 In READY with csbp=0 and webp=1, doutp SHALL take mem[addrp] on that edge (1-cycle read latency); otherwise doutp holds.
REQ-022 In READY with csbp=0 and webp=0, each byte i with wmaskp[i]=1 SHALL be written from dinp on that edge; unmasked bytes are unchanged; doutp holds.
REQ-023 Writes from both ports to the same address SHALL resolve per byte: port 1 wins where both masks are set; each port alone writes its own bytes.
REQ-024 A read on one port and a write on the other to the same address SHALL return the pre-write word when RDW_MODE=0.
REQ-025 With RDW_MODE=1, that read SHALL return the post-write word: written bytes new, unwritten bytes old.
REQ-026 Reads from both ports to the same address SHALL both return the stored word.
REQ-027 Reads and writes to different addresses SHALL be fully independent in the same cycle.

Reset
REQ-028 rst_n=0 SHALL immediately force the state to CLEAR, the counter to 0, ready to 0, and dout0 and dout1 to 0.
REQ-029 Reset SHALL NOT modify array contents directly; stale words are removed by the post-reset CLEAR sweep.
REQ-030 Asserting rst_n mid-sweep or mid-access SHALL abort the operation with no partial write completing after the assertion.

Verification
REQ-031 Release reset, ADDR_WIDTH=8 -> ready=0 for 256 edges, then 1; reading any address returns 0.
REQ-032 Port 0 writes 0xDEADBEEF to address 0x10 with wmask=4'b0101, then reads it -> dout0=0x00AD00EF one cycle later.
REQ-033 Same edge: port 0 writes 0x11111111 and port 1 writes 0x22222222 to address 5, both wmask=4'hF -> a later read returns 0x22222222.
REQ-034 Address 7 holds 0xAAAAAAAA; port 0 writes 0x55555555 to it while port 1 reads it -> dout1=0xAAAAAAAA with RDW_MODE=0, 0x55555555 with RDW_MODE=1.
REQ-035 flush in READY after writes, plus a write issued during CLEAR -> ready drops for 256 edges; all words read 0 afterwards and the write is lost.
REQ-036 rst_n pulled low asynchronously between edges while dout0=0x12345678 -> dout0=0 and ready=0 immediately, and a fresh 256-edge sweep follows.
